// File: rtl/bus_mem_if.sv
// Cache-to-memory bus: request and response channels, each with a valid/ready handshake.
// The master (cache) issues requests; the slave (memory) returns tagged responses.
interface bus_mem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128,
    parameter int ID_W   = 2
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic [ID_W-1:0]   req_id;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic [ID_W-1:0]   resp_id;

    modport master (
        output req_valid, req_we, req_addr, req_data, req_id, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_id
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_data, req_id, resp_ready,
        output req_ready, resp_valid, resp_data, resp_id
    );
endinterface

// File: rtl/bus_mem_model.sv
// In-order, fixed-latency line memory responder for the cache bus.
// Define BUSMEM_BACKPRESSURE_EN to add LFSR-driven req_ready/resp_valid stalls.
module bus_mem_model #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 128,
    parameter int ID_W            = 2,
    parameter int DEPTH           = 1024,
    parameter int LATENCY         = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input logic      clk,
    input logic      rst,
    bus_mem_if.slave mif
);
    localparam int OFF   = $clog2(DATA_W / 8);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int QC_W  = $clog2(MAX_OUTSTANDING) + 1;
    localparam int CD_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef logic [PTR_W-1:0] ptr_t;

    localparam ptr_t            PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [QC_W-1:0] MAX_C    = QC_W'(MAX_OUTSTANDING);
    localparam logic [CD_W-1:0] LAT_C    = CD_W'(LATENCY - 1);

    logic [DATA_W-1:0] mem_q  [DEPTH];
    logic [ID_W-1:0]   id_q   [MAX_OUTSTANDING];
    logic [DATA_W-1:0] data_q [MAX_OUTSTANDING];
    logic [CD_W-1:0]   cd_q   [MAX_OUTSTANDING];

    ptr_t              wr_ptr_q, wr_ptr_d;
    ptr_t              rd_ptr_q, rd_ptr_d;
    logic [QC_W-1:0]   count_q, count_d;
    logic [IDX_W-1:0]  idx;
    logic [ADDR_W-1:0] unused_addr;
    logic              accept;
    logic              pop;
    logic              head_ok;
    logic              stall_req;
    logic              stall_resp;

    function automatic ptr_t ptr_inc(ptr_t p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

`ifdef BUSMEM_BACKPRESSURE_EN
    logic [15:0] lfsr_q, lfsr_d;

    assign lfsr_d = {lfsr_q[14:0],
                     lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= 16'hACE1;
        else     lfsr_q <= lfsr_d;
    end

    assign stall_req  = (lfsr_q[1:0] == 2'b00);
    assign stall_resp = (lfsr_q[3:2] == 2'b00);
`else
    assign stall_req  = 1'b0;
    assign stall_resp = 1'b0;
`endif

    // Offset bits and bits above the index are dropped, so addresses alias.
    assign idx         = mif.req_addr[OFF +: IDX_W];
    assign unused_addr = mif.req_addr;

    // Ready looks only at the registered count to keep resp_ready off this path.
    assign mif.req_ready = !rst && (count_q < MAX_C) && !stall_req;

    assign head_ok = !rst && (count_q != '0)
                   && (cd_q[rd_ptr_q] == '0) && !stall_resp;

    assign mif.resp_valid = head_ok;
    assign mif.resp_id    = head_ok ? id_q[rd_ptr_q] : '0;
    assign mif.resp_data  = head_ok ? data_q[rd_ptr_q] : '0;

    assign accept = mif.req_valid && mif.req_ready;
    assign pop    = head_ok && mif.resp_ready;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (accept) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop)    rd_ptr_d = ptr_inc(rd_ptr_q);
        if (accept && !pop)      count_d = count_q + 1'b1;
        else if (pop && !accept) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Countdowns run freely; a read takes its data snapshot at acceptance.
    always_ff @(posedge clk) begin
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if (cd_q[i] != '0) cd_q[i] <= cd_q[i] - 1'b1;
        end
        if (accept) begin
            id_q[wr_ptr_q]   <= mif.req_id;
            data_q[wr_ptr_q] <= mif.req_we ? '0 : mem_q[idx];
            cd_q[wr_ptr_q]   <= LAT_C;
            if (mif.req_we) mem_q[idx] <= mif.req_data;
        end
    end
endmodule

// File: tb/tb_bus_mem_model.sv
// Randomised scoreboard bench for bus_mem_model: a driver predicts responses
// from an address-indexed reference memory, a monitor checks order, data and timing.
module tb_bus_mem_model;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 128;
    localparam int ID_W   = 2;
    localparam int DEPTH  = 1024;
    localparam int LAT    = 4;
    localparam int MAXO   = 4;
    localparam int LINE_B = DATA_W / 8;

    typedef struct {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        bit                chk;
        int                acc;
    } exp_t;

    logic clk;
    logic rst;

    exp_t              sb[$];
    logic [DATA_W-1:0] ref_mem [int];

    int cyc       = 0;
    int n_cmp     = 0;
    int n_err     = 0;
    int last_pop  = 0;
    int rr_mode   = 1;
    bit head_seen = 0;

    bus_mem_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) bif ();

    bus_mem_model #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W),
        .DEPTH(DEPTH), .LATENCY(LAT), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mif(bif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [DATA_W-1:0] act, logic [DATA_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic push(bit we, logic [ADDR_W-1:0] addr, logic [DATA_W-1:0] data,
                        logic [ID_W-1:0] id, int acc);
        exp_t e;
        int   line;
        line  = int'((addr / LINE_B) % DEPTH);
        e.id  = id;
        e.acc = acc;
        if (we) begin
            e.data = '0;
            e.chk  = 1'b1;
            ref_mem[line] = data;
        end else if (ref_mem.exists(line)) begin
            e.data = ref_mem[line];
            e.chk  = 1'b1;
        end else begin
            e.data = '0;
            e.chk  = 1'b0;
        end
        sb.push_back(e);
    endtask

    task automatic issue(bit we, logic [ADDR_W-1:0] addr, logic [DATA_W-1:0] data,
                         logic [ID_W-1:0] id);
        bit done;
        int acc_edge;
        done     = 1'b0;
        acc_edge = 0;
        bif.req_valid = 1'b1;
        bif.req_we    = we;
        bif.req_addr  = addr;
        bif.req_data  = data;
        bif.req_id    = id;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (bif.req_ready) begin
                done     = 1'b1;
                acc_edge = cyc + 1;
            end
            @(posedge clk);
            #1;
        end
        bif.req_valid = 1'b0;
        if (done) begin
            push(we, addr, data, id, acc_edge);
        end else begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: got no accept, required accept within 200 cycles");
        end
    endtask

    task automatic idle(int n);
        bif.req_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bif.resp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                0:       bif.resp_ready = 1'b0;
                1:       bif.resp_ready = 1'b1;
                default: bif.resp_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: the head of the scoreboard must appear exactly when its latency
    // and the previous pop allow, and stay stable until it is consumed.
    always @(negedge clk) begin
        exp_t h;
        int   vis;
        if (rst) begin
            chk("rst_resp_valid", DATA_W'(bif.resp_valid), '0);
            chk("rst_req_ready", DATA_W'(bif.req_ready), '0);
            chk("rst_resp_data", bif.resp_data, '0);
            chk("rst_resp_id", DATA_W'(bif.resp_id), '0);
            head_seen = 1'b0;
        end else begin
`ifndef BUSMEM_BACKPRESSURE_EN
            chk("req_ready", DATA_W'(bif.req_ready), DATA_W'(sb.size() < MAXO));
            if (head_seen && !bif.resp_valid) begin
                n_cmp++;
                n_err++;
                $display("FAIL resp_dropped: got resp_valid=0, required 1 until pop");
            end
`endif
            if (bif.resp_valid) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL resp_spurious: got resp id %0h, required no response",
                             bif.resp_id);
                end else begin
                    h = sb[0];
                    if (!head_seen) begin
                        head_seen = 1'b1;
                        vis = h.acc + LAT - 1;
                        if (last_pop > vis) vis = last_pop;
`ifndef BUSMEM_BACKPRESSURE_EN
                        chk("resp_latency", DATA_W'(cyc), DATA_W'(vis));
`else
                        chk("resp_not_early", DATA_W'(cyc >= vis), DATA_W'(1));
`endif
                    end
                    chk("resp_id", DATA_W'(bif.resp_id), DATA_W'(h.id));
                    if (h.chk) chk("resp_data", bif.resp_data, h.data);
                    if (bif.resp_ready) begin
                        void'(sb.pop_front());
                        last_pop  = cyc + 1;
                        head_seen = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        int                k;
        rst = 1'b1;
        bif.req_valid = 1'b0;
        bif.req_we    = 1'b0;
        bif.req_addr  = '0;
        bif.req_data  = '0;
        bif.req_id    = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        rr_mode = 1;
        issue(1'b1, 32'h40, 128'hDEADBEEF, 2'd1);
        issue(1'b0, 32'h40, '0, 2'd2);
        idle(8);

        rr_mode = 0;
        for (int i = 0; i < 4; i++) issue(1'b0, 32'h40 + 32'(i * LINE_B), '0, 2'(i));
        idle(4);
        rr_mode = 1;
        idle(10);

        issue(1'b0, 32'h40, '0, 2'd3);
        issue(1'b1, 32'h40, 128'h1, 2'd0);
        idle(8);
        issue(1'b0, 32'h4F, '0, 2'd1);
        idle(8);

        issue(1'b1, 32'h40, {4{32'hA5A5_0001}}, 2'd2);
        issue(1'b0, 32'h4040, '0, 2'd3);
        idle(8);

        rr_mode = 0;
        for (int i = 0; i < 3; i++) issue(1'b0, 32'h40, '0, 2'(i));
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        rr_mode = 1;
        idle(10);

        rr_mode = 2;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            a = 32'($urandom_range(0, 15) * LINE_B + $urandom_range(0, LINE_B - 1));
            if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_C000);
            d = {$urandom, $urandom, $urandom, $urandom};
            issue(1'($urandom_range(0, 1)), a, d, 2'($urandom_range(0, 3)));
        end

        rr_mode = 1;
        k = 0;
        while (sb.size() > 0 && k < 500) begin
            @(posedge clk);
            k++;
        end
        if (sb.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: got %0d responses pending, required 0", sb.size());
        end
        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
